// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - fixed-priority display ownership scheduler with minimum hold time
// Optional blink of source-0 digits enabled by define DISPLAY_SCHEDULER_BLINK_EN.
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned BLINK_DIV   = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] src0_num,
  input  logic [15:0] src1_num,
  input  logic [15:0] src2_num,
  input  logic [3:0]  src0_sel,
  input  logic [3:0]  src1_sel,
  input  logic [3:0]  src2_sel,
  input  logic [3:0]  blink_mask,
  output logic [2:0]  gnt,
  output logic [15:0] num,
  output logic [3:0]  sel,
  output logic        busy
);

  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_OWN      = 1'b1;
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] num_q, num_d;
  logic [3:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic [2:0]  above;

  function automatic logic [2:0] highest(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  // Request bits strictly higher in priority than the current one-hot owner.
  assign above = {gnt_q[1] | gnt_q[0], gnt_q[0], 1'b0};

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = highest(req);
          state_d = ST_OWN;
          hold_d  = HOLD_RELOAD;
        end else begin
          gnt_d  = 3'b000;
          hold_d = 16'd0;
        end
      end
      ST_OWN: begin
        if (req[2] && !gnt_q[2]) begin
          gnt_d  = 3'b100;
          hold_d = HOLD_RELOAD;
        end else if (hold_q != 16'd0) begin
          hold_d = hold_q - 16'd1;
        end else if (|(req & above)) begin
          gnt_d  = highest(req & above);
          hold_d = HOLD_RELOAD;
        end else if (|(req & gnt_q)) begin
          // Owner keeps the display; hold stays saturated at zero.
          hold_d = 16'd0;
        end else if (|req) begin
          gnt_d  = highest(req);
          hold_d = HOLD_RELOAD;
        end else begin
          gnt_d   = 3'b000;
          state_d = ST_IDLE;
          hold_d  = 16'd0;
        end
      end
      default: begin
        gnt_d   = 3'b000;
        state_d = ST_IDLE;
        hold_d  = 16'd0;
      end
    endcase
  end

`ifdef DISPLAY_SCHEDULER_BLINK_EN
  logic [BLINK_DIV-1:0] blink_cnt_q;
  logic                 blink_phase_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (&blink_cnt_q) blink_phase_q <= ~blink_phase_q;
    end
  end
`endif

  // Outputs follow the next owner so grant and data switch on the same edge.
  always_comb begin
    num_d = 16'h0000;
    sel_d = 4'b0000;
    case (gnt_d)
      3'b001: begin
        num_d = src0_num;
        sel_d = src0_sel;
`ifdef DISPLAY_SCHEDULER_BLINK_EN
        if (blink_phase_q) sel_d = src0_sel & ~blink_mask;
`endif
      end
      3'b010: begin
        num_d = src1_num;
        sel_d = src1_sel;
      end
      3'b100: begin
        num_d = src2_num;
        sel_d = src2_sel;
      end
      default: begin
        num_d = 16'h0000;
        sel_d = 4'b0000;
      end
    endcase
    busy_d = |gnt_d;
  end

`ifndef DISPLAY_SCHEDULER_BLINK_EN
  logic unused_blink;
  assign unused_blink = ^blink_mask;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      hold_q  <= 16'd0;
      num_q   <= 16'h0000;
      sel_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      num_q   <= num_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign num  = num_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] src0_num, src1_num, src2_num;
  logic [3:0]  src0_sel, src1_sel, src2_sel;
  logic [3:0]  blink_mask;
  logic [2:0]  gnt;
  logic [15:0] num;
  logic [3:0]  sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  display_scheduler #(.HOLD_CYCLES(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .src0_num(src0_num), .src1_num(src1_num), .src2_num(src2_num),
    .src0_sel(src0_sel), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .blink_mask(blink_mask),
    .gnt(gnt), .num(num), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic [15:0] n,
                           input logic [3:0] s, input logic b);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".num"}, 32'(num), 32'(n));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    int blinked;
    rst = 1'b0; req = 3'b000;
    src0_num = 16'h1234; src1_num = 16'hAAAA; src2_num = 16'hEEEE;
    src0_sel = 4'b1111;  src1_sel = 4'b0011;  src2_sel = 4'b1010;
    blink_mask = 4'b0001;
    step();
    check_out("reset", 3'b000, 16'h0000, 4'b0000, 1'b0);

    rst = 1'b1;
    step();
    check_out("idle_noreq", 3'b000, 16'h0000, 4'b0000, 1'b0);

    // Single request, one-cycle grant latency
    req = 3'b001;
    step();
    check_out("grant0", 3'b001, 16'h1234, 4'b1111, 1'b1);

    // Preemption by source 2 at hold 3
    req = 3'b101;
    step();
    check_out("preempt", 3'b100, 16'hEEEE, 4'b1010, 1'b1);
    req = 3'b001; src2_num = 16'hEEE1;
    step();
    check_out("hold2_a", 3'b100, 16'hEEE1, 4'b1010, 1'b1);
    step();
    check("hold2_b.gnt", 32'(gnt), 32'h4);
    step();
    check("hold2_c.gnt", 32'(gnt), 32'h4);
    step();
    check_out("hold2_expire", 3'b001, 16'h1234, 4'b1111, 1'b1);

    // Release owner 0 to idle
    req = 3'b000;
    step(); step(); step();
    check_out("release0_hold", 3'b001, 16'h1234, 4'b1111, 1'b1);
    step();
    check_out("release0_idle", 3'b000, 16'h0000, 4'b0000, 1'b0);

    // Simultaneous requests resolve to source 1, then fall to source 0
    req = 3'b011; src0_num = 16'h1111;
    step();
    check_out("simul", 3'b010, 16'hAAAA, 4'b0011, 1'b1);
    req = 3'b001;
    step();
    check("simul_h1.gnt", 32'(gnt), 32'h2);
    step();
    check("simul_h2.gnt", 32'(gnt), 32'h2);
    step();
    check("simul_h3.gnt", 32'(gnt), 32'h2);
    step();
    check_out("simul_switch", 3'b001, 16'h1111, 4'b1111, 1'b1);

    // Owner re-granted at hold 0 must not reload: a higher request wins next edge
    step(); step(); step(); step();
    check("regrant.gnt", 32'(gnt), 32'h1);
    req = 3'b011;
    step();
    check_out("regrant_noreload", 3'b010, 16'hAAAA, 4'b0011, 1'b1);

    // Release owner 1
    req = 3'b000;
    step(); step(); step();
    check("release1_hold.gnt", 32'(gnt), 32'h2);
    step();
    check_out("release1_idle", 3'b000, 16'h0000, 4'b0000, 1'b0);

    // Reset mid-ownership
    req = 3'b010;
    step(); step();
    check("pre_reset.gnt", 32'(gnt), 32'h2);
    rst = 1'b0;
    step();
    check_out("mid_reset", 3'b000, 16'h0000, 4'b0000, 1'b0);
    rst = 1'b1;
    step();
    check_out("post_reset", 3'b010, 16'hAAAA, 4'b0011, 1'b1);

    // All three requests from idle: source 2 wins
    rst = 1'b0;
    step();
    rst = 1'b1; req = 3'b111;
    step();
    check_out("prio_all", 3'b100, 16'hEEE1, 4'b1010, 1'b1);

    // Blink behaviour with source 0 owning
    rst = 1'b0;
    step();
    rst = 1'b1; req = 3'b001; src0_sel = 4'b1111; blink_mask = 4'b0001;
    step();
    blinked = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef DISPLAY_SCHEDULER_BLINK_EN
      if (sel === 4'b1110) blinked++;
      else check("blink_val", 32'(sel), 32'hF);
`else
      check("noblink_sel", 32'(sel), 32'hF);
      if (sel !== 4'b1111) blinked++;
`endif
      step();
    end
`ifdef DISPLAY_SCHEDULER_BLINK_EN
    check("blink_count", 32'(blinked), 32'd4);
`else
    check("noblink_count", 32'(blinked), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1024, giving the minimum number of cycles a non-preempted owner keeps the display (legal range 1..65535).
REQ-002 The block SHALL have parameter BLINK_DIV, default 22, giving the blink phase toggle period of 2^BLINK_DIV cycles (legal range 1..30).
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 req  in  3  display requests; bit0 = input entry, bit1 = result, bit2 = error.
REQ-006 src0_num / src1_num / src2_num  in  16 each  four-digit hex value from each source.
REQ-007 src0_sel / src1_sel / src2_sel  in  4 each  digit-enable mask from each source.
REQ-008 blink_mask  in  4  digits to blink while source 0 owns the display.
REQ-009 gnt  out  3  one-hot current owner, or 000 when idle.
REQ-010 num  out  16  value to the seven-segment driver, registered.
REQ-011 sel  out  4  digit enables to the seven-segment driver, registered.
REQ-012 busy  out  1  high while any owner is granted.

Function
REQ-013 The FSM SHALL have two states, IDLE and OWN; all outputs SHALL be registered.
REQ-014 IDLE: if req != 0, the next edge SHALL grant the highest set bit (2 > 1 > 0), enter OWN, and load hold_cnt = HOLD_CYCLES-1; otherwise it SHALL stay in IDLE with num=0, sel=0000.
REQ-015 Grant latency SHALL be exactly one cycle: req sampled at edge N gives gnt, num, sel and busy valid after edge N.
REQ-016 In OWN, num/sel SHALL track the owner's src*_num/src*_sel with one-cycle register latency, every cycle.
REQ-017 In OWN, hold_cnt SHALL decrement by 1 per cycle and saturate at 0.
REQ-018 When hold_cnt != 0, the owner SHALL be retained even if its req deasserts, except per REQ-019.
REQ-019 req[2] SHALL preempt owner 0 or 1 at the next edge regardless of hold_cnt, reloading hold_cnt.
REQ-020 When hold_cnt == 0: a set req bit higher than the owner SHALL switch ownership to it; else, if the owner's req is still high, the owner SHALL stay; else the highest pending req SHALL be granted; if none is pending, the FSM SHALL go to IDLE with gnt=000, num=0, sel=0000.
REQ-021 Every ownership change SHALL reload hold_cnt = HOLD_CYCLES-1, and gnt and num/sel SHALL switch on the same edge, with no intermediate cycle.
REQ-022 Re-granting the current owner SHALL NOT reload hold_cnt.
REQ-023 Simultaneous requests SHALL resolve by fixed priority only; gnt SHALL never have more than one bit set.

Reset
REQ-024 With rst=0 at an edge: state=IDLE, gnt=000, num=16'h0000, sel=4'b0000, busy=0, hold_cnt=0, blink counter=0.
REQ-025 Reset asserted mid-OWN SHALL abort ownership at that edge, and requests SHALL be re-arbitrated from IDLE on the first edge with rst=1.

Configuration
REQ-026 Macro DISPLAY_SCHEDULER_BLINK_EN SHALL enable the blink feature.
REQ-027 With the macro defined, a free-running BLINK_DIV-bit counter SHALL toggle a blink phase; while the phase is 1 and the owner is source 0, sel SHALL be src0_sel & ~blink_mask; otherwise sel follows REQ-016.
REQ-028 Without the macro, blink_mask SHALL be ignored, no blink counter SHALL exist, and sel always follows REQ-016.

Verification
Bench parameters: HOLD_CYCLES=4, BLINK_DIV=2.
REQ-029 Single request: rst released, req=001, src0_num=16'h1234, src0_sel=1111 -> one edge later gnt=001, num=1234, sel=1111, busy=1.
REQ-030 Simultaneous requests: req=011 from IDLE -> gnt=010; drop req[1] at hold cycle 1 -> gnt stays 010 until hold_cnt=0, then switches to 001 with num=src0_num on the same edge.
REQ-031 Preemption: owner 0 at hold_cnt=3, assert req[2] with src2_num=16'hEEEE -> next edge gnt=100, num=EEEE, hold_cnt reloaded to 3.
REQ-032 Release: owner 1, req drops to 000 -> after hold expires, IDLE next edge with gnt=000, num=0000, sel=0000, busy=0.
REQ-033 Reset mid-OWN: rst=0 for one edge while gnt=010 -> all outputs at reset values; with req=010 held, gnt=010 again one edge after rst returns to 1.
REQ-034 Blink (macro defined): owner 0, src0_sel=1111, blink_mask=0001 -> sel alternates 1111 and 1110 every 4 cycles; macro undefined -> sel constant 1111.
